// File: rtl/alu_stateful_if.sv
// Operand/result bundle between the action crossbar, one alu_stateful lane and PHV merge.
// master = crossbar + merge side, slave = the ALU.
interface alu_stateful_if #(
    parameter int unsigned ACTION_LEN = 25,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ACTION_LEN-1:0] action_in;
    logic [DATA_WIDTH-1:0] operand_1_in;
    logic [DATA_WIDTH-1:0] operand_2_in;
    logic [DATA_WIDTH-1:0] operand_3_in;
    logic                  in_valid;
    logic                  ready_out;
    logic [DATA_WIDTH-1:0] container_out;
    logic                  container_out_valid;
    logic                  ready_in;

    modport master (
        output action_in, operand_1_in, operand_2_in, operand_3_in, in_valid, ready_in,
        input  ready_out, container_out, container_out_valid
    );

    modport slave (
        input  action_in, operand_1_in, operand_2_in, operand_3_in, in_valid, ready_in,
        output ready_out, container_out, container_out_valid
    );
endinterface

// File: rtl/alu_stateful.sv
// Per-container 4B ALU of an RMT action stage: S1 operand/address capture, S2 compute
// and state-array write, with S2->S1 write forwarding and ready/valid backpressure.
module alu_stateful #(
    parameter int unsigned STAGE_ID   = 0,
    parameter int unsigned ACTION_LEN = 25,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input logic           clk,
    input logic           rst_n,
    alu_stateful_if.slave bus
);
    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    localparam logic [3:0] OpAdd   = 4'b0001;
    localparam logic [3:0] OpSub   = 4'b0010;
    localparam logic [3:0] OpLoadd = 4'b0111;
    localparam logic [3:0] OpStore = 4'b1000;
    localparam logic [3:0] OpAddi  = 4'b1001;
    localparam logic [3:0] OpSubi  = 4'b1010;
    localparam logic [3:0] OpLoad  = 4'b1011;
    localparam logic [3:0] OpSet   = 4'b1110;

    logic                  s1_valid_q, s1_valid_d;
    logic [3:0]            s1_op_q, s1_op_d;
    logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [3:0]            s2_op_q, s2_op_d;
    logic [DATA_WIDTH-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d, s2_c_q, s2_c_d;
    logic [DATA_WIDTH-1:0] s2_rdata_q, s2_rdata_d;
    logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    logic                  stall, adv, accept;
    logic [DATA_WIDTH-1:0] result, wr_data, rd_data;
    logic                  wr_en;

    logic unused_bits;
    assign unused_bits = ^{bus.action_in[ACTION_LEN-5:0], 32'(STAGE_ID)};

    assign stall                   = out_valid_q & ~bus.ready_in;
    assign adv                     = ~stall;
    assign accept                  = bus.in_valid & adv;
    assign bus.ready_out           = adv;
    assign bus.container_out       = out_data_q;
    assign bus.container_out_valid = out_valid_q;

    always_comb begin
        result  = s2_a_q;
        wr_data = s2_rdata_q + 1'b1;
        wr_en   = 1'b0;
        case (s2_op_q)
            OpAdd, OpAddi, OpSet: result = s2_a_q + s2_b_q;
            OpSub, OpSubi:        result = s2_a_q - s2_b_q;
            OpLoad:               result = s2_rdata_q;
            OpStore: begin
                result  = s2_c_q;
                wr_data = s2_a_q;
                wr_en   = 1'b1;
            end
            OpLoadd: begin
                result = s2_rdata_q + 1'b1;
                wr_en  = 1'b1;
            end
            default: result = s2_a_q;
        endcase
        // A write commits only on the cycle its beat leaves S2.
        wr_en = wr_en & s2_valid_q & adv;
    end

    // S1 reads on the same edge S2 writes, so a matching address takes the write data.
    assign rd_data = (wr_en && (s2_addr_q == s1_addr_q)) ? wr_data : mem_q[s1_addr_q];

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_c_d      = s1_c_q;
        s1_addr_d   = s1_addr_q;
        s2_valid_d  = s2_valid_q;
        s2_op_d     = s2_op_q;
        s2_a_d      = s2_a_q;
        s2_b_d      = s2_b_q;
        s2_c_d      = s2_c_q;
        s2_addr_d   = s2_addr_q;
        s2_rdata_d  = s2_rdata_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (adv) begin
            s1_valid_d  = bus.in_valid;
            s2_valid_d  = s1_valid_q;
            out_valid_d = s2_valid_q;
            if (accept) begin
                s1_op_d   = bus.action_in[ACTION_LEN-1 -: 4];
                s1_a_d    = bus.operand_1_in;
                s1_b_d    = bus.operand_2_in;
                s1_c_d    = bus.operand_3_in;
                s1_addr_d = bus.operand_2_in[ADDR_WIDTH-1:0];
            end
            if (s1_valid_q) begin
                s2_op_d    = s1_op_q;
                s2_a_d     = s1_a_q;
                s2_b_d     = s1_b_q;
                s2_c_d     = s1_c_q;
                s2_addr_d  = s1_addr_q;
                s2_rdata_d = rd_data;
            end
            if (s2_valid_q) begin
                out_data_d = result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_c_q      <= '0;
            s1_addr_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_op_q     <= '0;
            s2_a_q      <= '0;
            s2_b_q      <= '0;
            s2_c_q      <= '0;
            s2_addr_q   <= '0;
            s2_rdata_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_c_q      <= s1_c_d;
            s1_addr_q   <= s1_addr_d;
            s2_valid_q  <= s2_valid_d;
            s2_op_q     <= s2_op_d;
            s2_a_q      <= s2_a_d;
            s2_b_q      <= s2_b_d;
            s2_c_q      <= s2_c_d;
            s2_addr_q   <= s2_addr_d;
            s2_rdata_q  <= s2_rdata_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // State array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[s2_addr_q] <= wr_data;
        end
    end
endmodule

// File: tb/tb_alu_stateful.sv
// Bench for alu_stateful: directed and random beats scored against a serialized
// reference of the opcode rules and a 32-entry state array.
module tb_alu_stateful;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_stateful_if #(.ACTION_LEN(25), .DATA_WIDTH(32)) bus ();

    alu_stateful #(
        .STAGE_ID  (0),
        .ACTION_LEN(25),
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem[32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Each accepted beat is applied to the model in acceptance order, i.e. fully serialized.
    task automatic model_accept(input logic [3:0] op, input logic [31:0] a, b, c);
        int          addr;
        logic [31:0] r;
        addr = int'(b[4:0]);
        case (op)
            4'd1, 4'd9, 4'd14: r = a + b;
            4'd2, 4'd10:       r = a - b;
            4'd11:             r = model_mem[addr];
            4'd8: begin
                model_mem[addr] = a;
                r = c;
            end
            4'd7: begin
                model_mem[addr] = model_mem[addr] + 32'd1;
                r = model_mem[addr];
            end
            default:           r = a;
        endcase
        exp_q.push_back(r);
    endtask

    task automatic beat(input logic [3:0] op, input logic [31:0] a, b, c);
        int guard;
        @(negedge clk);
        bus.action_in    = {op, 21'($urandom)};
        bus.operand_1_in = a;
        bus.operand_2_in = b;
        bus.operand_3_in = c;
        bus.in_valid     = 1'b1;
        #1;
        guard = 0;
        while (!bus.ready_out && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("accept_bound", 32'(guard >= 100), 32'd0);
        model_accept(op, a, b, c);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic lat_step(input string tag, input logic exp_valid);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #3;
        chk(tag, 32'(bus.container_out_valid), 32'(exp_valid));
    endtask

    // Result monitor: every valid output must match the oldest outstanding expectation.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && bus.container_out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("result", bus.container_out, exp_q[0]);
                chk("ready_out_busy", 32'(bus.ready_out), 32'(bus.ready_in));
                if (bus.ready_in) void'(exp_q.pop_front());
            end
        end else begin
            chk("ready_out_idle", 32'(bus.ready_out), 32'd1);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops[11];
        int         g;
        ops = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd14, 4'd11, 4'd8, 4'd7, 4'd0, 4'd3, 4'd15};
        bus.action_in    = '0;
        bus.operand_1_in = '0;
        bus.operand_2_in = '0;
        bus.operand_3_in = '0;
        bus.in_valid     = 1'b0;
        bus.ready_in     = 1'b1;

        repeat (2) @(negedge clk);
        #2;
        chk("rst_valid", 32'(bus.container_out_valid), 32'd0);
        chk("rst_data", bus.container_out, 32'd0);
        chk("rst_ready", 32'(bus.ready_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: valid two edges after accept, for exactly one cycle.
        beat(4'b0001, 32'd5, 32'd7, 32'd0);
        lat_step("lat_edge1", 1'b0);
        lat_step("lat_edge2", 1'b0);
        lat_step("lat_edge3", 1'b1);
        chk("add_value", bus.container_out, 32'd12);
        lat_step("lat_pulse", 1'b0);

        // Wraparound.
        beat(4'b1010, 32'd3, 32'd5, 32'd0);
        beat(4'b0001, 32'hFFFF_FFFF, 32'd1, 32'd0);
        idle(4);

        // Store then load via forwarding, then from the array.
        beat(4'b1000, 32'hDEAD_BEEF, 32'd3, 32'h11);
        beat(4'b1011, 32'd0, 32'd3, 32'd0);
        idle(3);
        beat(4'b1011, 32'd0, 32'd3, 32'd0);
        idle(4);

        // Back-to-back loadd.
        beat(4'b1000, 32'd10, 32'd7, 32'd0);
        repeat (3) beat(4'b0111, 32'd0, 32'd7, 32'd0);
        beat(4'b1011, 32'd0, 32'd7, 32'd0);
        idle(5);

        // Backpressure on a burst of four adds.
        for (int i = 1; i <= 3; i++) beat(4'b0001, 32'd0, 32'(i), 32'd0);
        bus.ready_in = 1'b0;
        fork
            beat(4'b0001, 32'd0, 32'd4, 32'd0);
            begin
                repeat (4) @(negedge clk);
                bus.ready_in = 1'b1;
            end
        join
        idle(6);

        // A loadd held in S2 by a stall must increment once.
        beat(4'b1000, 32'd20, 32'd9, 32'd0);
        beat(4'b0111, 32'd0, 32'd9, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.ready_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.ready_in = 1'b1;
        beat(4'b1011, 32'd0, 32'd9, 32'd0);
        idle(5);

        // Reset while a loadd sits in S2: its increment is dropped.
        beat(4'b1000, 32'd5, 32'd2, 32'd0);
        idle(5);
        beat(4'b0111, 32'd0, 32'd2, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.container_out_valid), 32'd0);
        chk("midrst_ready", 32'(bus.ready_out), 32'd1);
        chk("midrst_data", bus.container_out, 32'd0);
        exp_q.delete();
        model_mem[2] = 32'd5;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        beat(4'b1011, 32'd0, 32'd2, 32'd0);
        idle(5);

        // Random traffic over a few hot addresses with random backpressure.
        for (int i = 0; i < 4; i++) beat(4'b1000, $urandom, 32'(i), $urandom);
        idle(4);
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [31:0] b;
                    b = ($urandom & ~32'h1F) | 32'($urandom_range(0, 3));
                    beat(ops[$urandom_range(0, 10)], $urandom, b, $urandom);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                idle(1);
            end
            begin
                repeat (450) begin
                    @(negedge clk);
                    bus.ready_in = ($urandom_range(0, 3) != 0);
                end
                bus.ready_in = 1'b1;
            end
        join

        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_stateful.md
# alu_stateful

Per-container 4-byte ALU of an RMT action stage, sitting directly downstream of the action crossbar. It takes one 4B lane of crossbar operands, one 25-bit sub-action and a 1-cycle-delayed valid, and computes the new container value. Supported operations are arithmetic, immediate, set, and stateful load/store/increment against a small local register array. It is a two-stage pipeline with read-after-write forwarding and a ready/valid backpressure path toward the crossbar.

## Interface
Parameters:
- STAGE_ID, 0, stage index; informational, no functional effect.
- ACTION_LEN, 25, sub-action width.
- DATA_WIDTH, 32, container and operand width.
- ADDR_WIDTH, 5, state array address width; array depth is 2^ADDR_WIDTH.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- action_in  in  ACTION_LEN  sub-action; opcode is action_in[24:21].
- operand_1_in  in  DATA_WIDTH  operand A (crossbar alu_in_4B_1 lane).
- operand_2_in  in  DATA_WIDTH  operand B or immediate (alu_in_4B_2 lane); bits [ADDR_WIDTH-1:0] give the state address.
- operand_3_in  in  DATA_WIDTH  original container value (alu_in_4B_3 lane).
- in_valid  in  1  operands and action valid this cycle.
- ready_out  out  1  block can accept a beat this cycle.
- container_out  out  DATA_WIDTH  result container.
- container_out_valid  out  1  result valid.
- ready_in  in  1  downstream (PHV merge) can accept the result.

## Operation
- Accept condition: in_valid & ready_out. A beat presented while ready_out=0 is not accepted; upstream holds it.
- Stage 1 (S1): register the opcode, operands and address. Issue a synchronous array read at that address.
- Stage 2 (S2): compute the result, register it to container_out, and perform any array write.
- Opcodes; all arithmetic is modulo 2^DATA_WIDTH with no saturation or flags:
  - 0001 add, 1001 addi: A+B.
  - 0010 sub, 1010 subi: A-B.
  - 1110 set: A+B. The crossbar forces A=0, so the result is the immediate.
  - 1011 load: result = mem[addr]; no write.
  - 1000 store: mem[addr] <= A; result = operand_3 (container unchanged).
  - 0111 loadd: mem[addr] <= mem[addr]+1; result = the incremented value.
  - Any other opcode: result = A (pass-through; the crossbar puts the original container in A).
- Forwarding: if S2 writes address X in the same cycle that S1 reads X, S1 uses the S2 write data, not the array output. Back-to-back loadd/store/load on the same address must behave as if fully serialized.
- The state array is not cleared by reset; contents are retained across rst_n. Software stores before it loads.

## Timing
- Latency: an accepted beat at edge N produces container_out_valid=1 after edge N+2, provided there is no stall.
- Throughput: one beat per cycle.
- Stall = container_out_valid & ~ready_in.
- ready_out = ~stall (combinational).
- During a stall, S1, S2, container_out and container_out_valid hold their values. No array write occurs while the owning beat is stalled in S2; the write commits exactly once, on the cycle the beat advances.
- When not stalled and S2 is empty of valid data, container_out_valid drops to 0 and container_out holds its last value.
- Reset (asynchronous, mid-operation included) drives:
  - container_out_valid=0, container_out=0.
  - All S1/S2 valid bits to 0, so in-flight beats are discarded and their array writes are not performed.
  - ready_out=1 immediately.
- Simultaneous accept and stall cannot occur, because ready_out=0 during a stall.

## Test plan
- Add: op 0001, A=5, B=7, single beat → container_out=12, valid 2 cycles after accept, valid for exactly 1 cycle with ready_in=1.
- Subtract wrap: op 1010, A=3, B=5 → 0xFFFFFFFE; op 0001, A=0xFFFFFFFF, B=1 → 0x00000000.
- Store/load: store A=0xDEADBEEF, addr 3, op3=0x11 → output 0x11. Next cycle, load addr 3 → 0xDEADBEEF via the forwarding path. Repeat the load with a 3-cycle gap → 0xDEADBEEF from the array.
- Back-to-back loadd: store 10 at addr 7, then three consecutive loadd at addr 7 → 11, 12, 13; a subsequent load at addr 7 → 13.
- Backpressure: send four add beats with results 1, 2, 3, 4; hold ready_in=0 for 3 cycles once the first result is valid → ready_out=0 during the hold, outputs frozen at 1, then released in order 1, 2, 3, 4 with no loss or duplication. A loadd stalled in S2 increments its location only once.
- Reset mid-flight: accept loadd addr 2 (mem=5), assert rst_n=0 while it is in S2 → valid=0 and ready_out=1 at once; after release, load addr 2 → 5.
